ecc_read_responder: RTL and testbench

- Downstream stage of correction_detection on the memory read path.
- Accepts raw read beats (address, 32-bit data, 7-bit SEC-DED parity) and drives them through correction_detection.
- Returns corrected data to the requester with an uncorrectable flag, and issues a scrub writeback of the corrected word on a correctable error.
- Keeps saturating CE/UE counters and a last-error address log for status reporting.

---
 rtl/ecc_pkg.sv | 21 ++
 rtl/ecc_read_responder_if.sv | 37 +++
 rtl/correction_detection.sv | 69 ++++++
 rtl/ecc_read_responder.sv | 162 ++++++++++++++++
 tb/tb_ecc_read_responder.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared widths, FSM states and parity helper for the ECC read path
package ecc_pkg;

    localparam int DATA_W = 32;
    localparam int PAR_W  = 7;
    localparam int HAM_W  = 6;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        RESP,
        WB
    } state_t;

    // Even overall parity across data and Hamming bits.
    function automatic logic overall_parity(input logic [DATA_W-1:0] data,
                                            input logic [HAM_W-1:0]  ham);
        return (^data) ^ (^ham);
    endfunction

endpackage

// File: rtl/ecc_read_responder_if.sv
// rtl/ecc_read_responder_if.sv - read beat, response and scrub writeback handshakes
interface ecc_read_responder_if
    import ecc_pkg::*;
#(
    parameter int ADDR_W = 16
);

    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [PAR_W-1:0]  rd_parity;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_uerr;

    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [PAR_W-1:0]  wb_parity;

    modport master (
        output rd_valid, rd_addr, rd_data, rd_parity, resp_ready, wb_ready,
        input  rd_ready, resp_valid, resp_data, resp_uerr,
               wb_valid, wb_addr, wb_data, wb_parity
    );

    modport slave (
        input  rd_valid, rd_addr, rd_data, rd_parity, resp_ready, wb_ready,
        output rd_ready, resp_valid, resp_data, resp_uerr,
               wb_valid, wb_addr, wb_data, wb_parity
    );

endinterface

// File: rtl/correction_detection.sv
// rtl/correction_detection.sv - combinational SEC-DED check and single-bit correction
// Hamming positions 1..38 with check bits at powers of two; parity[6] is even overall parity.
module correction_detection
    import ecc_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    input  logic [PAR_W-1:0]  parity_in,
    output logic [DATA_W-1:0] sec_corrected_data,
    output logic [PAR_W-1:0]  sec_corrected_parity,
    output logic              single_error,
    output logic              double_error
);

    function automatic logic [HAM_W-1:0] data_pos(input int idx);
        int              n;
        logic [HAM_W-1:0] p;
        n = 0;
        p = '0;
        for (int q = 3; q < 39; q++) begin
            if ((q & (q - 1)) != 0) begin
                if (n == idx) p = HAM_W'(q);
                n++;
            end
        end
        return p;
    endfunction

    logic [HAM_W-1:0] pos_tab [DATA_W];
    logic [HAM_W-1:0] ham_calc;
    logic [HAM_W-1:0] syndrome;
    logic             overall_err;
    logic             pos_valid;

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pos
        assign pos_tab[gi] = data_pos(gi);
    end

    always_comb begin
        ham_calc = '0;
        for (int i = 0; i < DATA_W; i++) begin
            for (int b = 0; b < HAM_W; b++) begin
                if (pos_tab[i][b]) ham_calc[b] = ham_calc[b] ^ data_in[i];
            end
        end
    end

    assign syndrome    = ham_calc ^ parity_in[HAM_W-1:0];
    assign overall_err = (^data_in) ^ (^parity_in);
    assign pos_valid   = (syndrome <= HAM_W'(38));

    // An odd flip count pointing outside the codeword can only be a multi-bit error.
    assign single_error = overall_err & pos_valid;
    assign double_error = ((syndrome != '0) & ~overall_err) | (overall_err & ~pos_valid);

    always_comb begin
        sec_corrected_data   = data_in;
        sec_corrected_parity = parity_in;
        if (single_error) begin
            if (syndrome == '0) sec_corrected_parity[PAR_W-1] = ~parity_in[PAR_W-1];
            for (int b = 0; b < HAM_W; b++) begin
                if (syndrome == HAM_W'(1 << b)) sec_corrected_parity[b] = ~parity_in[b];
            end
            for (int i = 0; i < DATA_W; i++) begin
                if (syndrome == pos_tab[i]) sec_corrected_data[i] = ~data_in[i];
            end
        end
    end

endmodule

// File: rtl/ecc_read_responder.sv
// rtl/ecc_read_responder.sv - corrects read beats, responds, scrubs CEs, tracks error stats
// One beat in flight at a time: IDLE -> DECODE -> RESP -> (WB) -> IDLE.
module ecc_read_responder
    import ecc_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
)(
    input  logic                 clk,
    input  logic                 rst,
    ecc_read_responder_if.slave  bus,
    input  logic                 scrub_en,
    input  logic                 clr_counts,
    output logic [CNT_W-1:0]     ce_count,
    output logic [CNT_W-1:0]     ue_count,
    output logic                 last_err_valid,
    output logic [ADDR_W-1:0]    last_err_addr,
    output logic                 last_err_ue
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] raw_data_q, raw_data_d;
    logic [PAR_W-1:0]  raw_par_q, raw_par_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [HAM_W-1:0]  par_q, par_d;
    logic              ce_q, ce_d;
    logic              ue_q, ue_d;

    logic [CNT_W-1:0]  ce_cnt_q, ce_cnt_d;
    logic [CNT_W-1:0]  ue_cnt_q, ue_cnt_d;
    logic              log_valid_q, log_valid_d;
    logic [ADDR_W-1:0] log_addr_q, log_addr_d;
    logic              log_ue_q, log_ue_d;

    logic [DATA_W-1:0] cd_data;
    logic [PAR_W-1:0]  cd_parity;
    logic              cd_single;
    logic              cd_double;
    logic              dec_ce;
    logic              dec_ue;

    correction_detection u_cd (
        .data_in              (raw_data_q),
        .parity_in            (raw_par_q),
        .sec_corrected_data   (cd_data),
        .sec_corrected_parity (cd_parity),
        .single_error         (cd_single),
        .double_error         (cd_double)
    );

    assign dec_ce = cd_single & ~cd_double;
    assign dec_ue = cd_double;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        raw_data_d = raw_data_q;
        raw_par_d  = raw_par_q;
        data_d     = data_q;
        par_d      = par_q;
        ce_d       = ce_q;
        ue_d       = ue_q;
        unique case (state_q)
            IDLE: begin
                if (bus.rd_valid) begin
                    addr_d     = bus.rd_addr;
                    raw_data_d = bus.rd_data;
                    raw_par_d  = bus.rd_parity;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                data_d  = cd_data;
                par_d   = cd_parity[HAM_W-1:0];
                ce_d    = dec_ce;
                ue_d    = dec_ue;
                state_d = RESP;
            end
            RESP: begin
                if (bus.resp_ready) state_d = (ce_q && scrub_en) ? WB : IDLE;
            end
            WB: begin
                if (bus.wb_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Clearing takes priority over an error landing on the same edge.
    always_comb begin
        ce_cnt_d    = ce_cnt_q;
        ue_cnt_d    = ue_cnt_q;
        log_valid_d = log_valid_q;
        log_addr_d  = log_addr_q;
        log_ue_d    = log_ue_q;
        if (clr_counts) begin
            ce_cnt_d    = '0;
            ue_cnt_d    = '0;
            log_valid_d = 1'b0;
            log_addr_d  = '0;
            log_ue_d    = 1'b0;
        end else if (state_q == DECODE) begin
            if (dec_ce && (ce_cnt_q != '1)) ce_cnt_d = ce_cnt_q + CNT_W'(1);
            if (dec_ue && (ue_cnt_q != '1)) ue_cnt_d = ue_cnt_q + CNT_W'(1);
            if (dec_ce || dec_ue) begin
                log_valid_d = 1'b1;
                log_addr_d  = addr_q;
                log_ue_d    = dec_ue;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            raw_data_q  <= '0;
            raw_par_q   <= '0;
            data_q      <= '0;
            par_q       <= '0;
            ce_q        <= 1'b0;
            ue_q        <= 1'b0;
            ce_cnt_q    <= '0;
            ue_cnt_q    <= '0;
            log_valid_q <= 1'b0;
            log_addr_q  <= '0;
            log_ue_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            raw_data_q  <= raw_data_d;
            raw_par_q   <= raw_par_d;
            data_q      <= data_d;
            par_q       <= par_d;
            ce_q        <= ce_d;
            ue_q        <= ue_d;
            ce_cnt_q    <= ce_cnt_d;
            ue_cnt_q    <= ue_cnt_d;
            log_valid_q <= log_valid_d;
            log_addr_q  <= log_addr_d;
            log_ue_q    <= log_ue_d;
        end
    end

    // rd_ready is gated by rst so every output reads 0 while reset is held.
    assign bus.rd_ready   = (state_q == IDLE) & ~rst;
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_data  = data_q;
    assign bus.resp_uerr  = ue_q;
    assign bus.wb_valid   = (state_q == WB);
    assign bus.wb_addr    = addr_q;
    assign bus.wb_data    = data_q;
    assign bus.wb_parity  = {overall_parity(data_q, par_q), par_q};

    assign ce_count       = ce_cnt_q;
    assign ue_count       = ue_cnt_q;
    assign last_err_valid = log_valid_q;
    assign last_err_addr  = log_addr_q;
    assign last_err_ue    = log_ue_q;

endmodule

// File: tb/tb_ecc_read_responder.sv
// tb/tb_ecc_read_responder.sv - directed and random beats against a nearest-codeword model
module tb_ecc_read_responder;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scrub_en = 1'b0;
    logic clr_counts = 1'b0;
    logic [CNT_W-1:0]  ce_count, ue_count;
    logic              last_err_valid, last_err_ue;
    logic [ADDR_W-1:0] last_err_addr;

    int n_checks = 0;
    int n_fails  = 0;

    int                m_ce = 0, m_ue = 0;
    logic              m_lv = 1'b0, m_lue = 1'b0;
    logic [ADDR_W-1:0] m_la = '0;

    ecc_read_responder_if #(.ADDR_W(ADDR_W)) bus ();

    ecc_read_responder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .scrub_en       (scrub_en),
        .clr_counts     (clr_counts),
        .ce_count       (ce_count),
        .ue_count       (ue_count),
        .last_err_valid (last_err_valid),
        .last_err_addr  (last_err_addr),
        .last_err_ue    (last_err_ue)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: data fills non-power-of-two positions 1..38 in order.
    function automatic logic [6:0] golden_par(input logic [31:0] d);
        logic [5:0] h;
        int         k;
        h = '0;
        k = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                for (int b = 0; b < 6; b++) if (pos[b]) h[b] = h[b] ^ d[k];
                k++;
            end
        end
        return {(^d) ^ (^h), h};
    endfunction

    // Nearest-codeword decode: 0 clean, 1 one flip from a codeword, 2 otherwise.
    function automatic void classify(input logic [31:0] d, input logic [6:0] p,
                                     output int kind, output logic [31:0] cd);
        logic [38:0] t;
        kind = 2;
        cd   = d;
        if (golden_par(d) == p) begin
            kind = 0;
        end else begin
            for (int i = 0; i < 39; i++) begin
                t = {p, d};
                t[i] = ~t[i];
                if (golden_par(t[31:0]) == t[38:32]) begin
                    kind = 1;
                    cd   = t[31:0];
                end
            end
        end
    endfunction

    task automatic run_beat(input logic [15:0] a, input logic [31:0] d, input logic [6:0] p,
                            input logic scrub, input int resp_stall, input int wb_stall,
                            input logic clr);
        int          kind;
        logic [31:0] cd;
        logic        exp_wb;
        classify(d, p, kind, cd);
        if (clr) begin
            m_ce = 0; m_ue = 0; m_lv = 1'b0; m_la = '0; m_lue = 1'b0;
        end else if (kind != 0) begin
            if (kind == 1 && m_ce < int'(CNT_MAX)) m_ce++;
            if (kind == 2 && m_ue < int'(CNT_MAX)) m_ue++;
            m_lv = 1'b1; m_la = a; m_lue = (kind == 2);
        end
        exp_wb = (kind == 1) && scrub;

        check("idle_rd_ready", bus.rd_ready, 1);
        bus.rd_valid = 1'b1; bus.rd_addr = a; bus.rd_data = d; bus.rd_parity = p;
        bus.resp_ready = 1'b0; bus.wb_ready = 1'b0;
        @(posedge clk); #1;
        bus.rd_valid = 1'b0;
        bus.rd_data  = ~d;
        if (clr) clr_counts = 1'b1;
        check("decode_rd_ready", bus.rd_ready, 0);
        check("decode_resp_valid", bus.resp_valid, 0);
        @(posedge clk); #1;
        clr_counts = 1'b0;
        scrub_en = ~scrub;
        check("ce_count", ce_count, m_ce);
        check("ue_count", ue_count, m_ue);
        check("last_err_valid", last_err_valid, m_lv);
        check("last_err_addr", last_err_addr, m_la);
        check("last_err_ue", last_err_ue, m_lue);
        for (int c = 0; c <= resp_stall; c++) begin
            check("resp_valid", bus.resp_valid, 1);
            check("resp_uerr", bus.resp_uerr, kind == 2);
            if (kind != 2) check("resp_data", bus.resp_data, cd);
            check("resp_rd_ready", bus.rd_ready, 0);
            check("resp_wb_valid", bus.wb_valid, 0);
            if (c == resp_stall) begin
                scrub_en = scrub;
                bus.resp_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b0;
        scrub_en = ~scrub;
        check("post_resp_valid", bus.resp_valid, 0);
        if (exp_wb) begin
            for (int c = 0; c <= wb_stall; c++) begin
                check("wb_valid", bus.wb_valid, 1);
                check("wb_addr", bus.wb_addr, a);
                check("wb_data", bus.wb_data, cd);
                check("wb_parity", bus.wb_parity, golden_par(cd));
                check("wb_rd_ready", bus.rd_ready, 0);
                if (c == wb_stall) bus.wb_ready = 1'b1;
                @(posedge clk); #1;
            end
            bus.wb_ready = 1'b0;
        end
        check("end_wb_valid", bus.wb_valid, 0);
        check("end_rd_ready", bus.rd_ready, 1);
        scrub_en = 1'b0;
    endtask

    initial begin
        logic [31:0] g, d;
        logic [6:0]  gp, p;
        logic [38:0] cw;
        int          nflip, i0, i1;

        bus.rd_valid = 1'b0; bus.rd_addr = '0; bus.rd_data = '0; bus.rd_parity = '0;
        bus.resp_ready = 1'b0; bus.wb_ready = 1'b0;
        g  = 32'hDEADBEEF;
        gp = golden_par(g);

        #12;
        check("rst_rd_ready", bus.rd_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_resp_data", bus.resp_data, 0);
        check("rst_wb_parity", bus.wb_parity, 0);
        check("rst_ce_count", ce_count, 0);
        check("rst_last_err_valid", last_err_valid, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        run_beat(16'h0010, g, gp, 1'b1, 0, 0, 1'b0);
        d = g; d[5] = ~d[5];
        run_beat(16'h0042, d, gp, 1'b1, 0, 0, 1'b0);
        d = g; d[3] = ~d[3]; d[17] = ~d[17];
        run_beat(16'h0100, d, gp, 1'b1, 0, 0, 1'b0);
        d = g; d[30] = ~d[30];
        run_beat(16'h0200, d, gp, 1'b1, 5, 4, 1'b0);

        for (int n = 0; n < 5; n++) begin
            d = $urandom; p = golden_par(d);
            d[n * 6] = ~d[n * 6];
            run_beat(16'(16'h0300 + n), d, p, n[0], 0, 0, 1'b0);
        end
        d = $urandom; p = golden_par(d); p[2] = ~p[2];
        run_beat(16'h0400, d, p, 1'b1, 0, 0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            d  = $urandom;
            cw = {golden_par(d), d};
            nflip = $urandom_range(0, 2);
            i0 = $urandom_range(0, 38);
            i1 = (i0 + $urandom_range(1, 38)) % 39;
            if (nflip >= 1) cw[i0] = ~cw[i0];
            if (nflip == 2) cw[i1] = ~cw[i1];
            run_beat(16'($urandom), cw[31:0], cw[38:32], 1'($urandom), $urandom_range(0, 2),
                     $urandom_range(0, 2), 1'b0);
        end

        d = g; d[9] = ~d[9];
        bus.rd_valid = 1'b1; bus.rd_addr = 16'h0777; bus.rd_data = d; bus.rd_parity = gp;
        scrub_en = 1'b1;
        @(posedge clk); #1;
        bus.rd_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_resp_valid", bus.resp_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_resp_valid", bus.resp_valid, 0);
        check("mid_rst_resp_data", bus.resp_data, 0);
        check("mid_rst_resp_uerr", bus.resp_uerr, 0);
        check("mid_rst_wb_valid", bus.wb_valid, 0);
        check("mid_rst_wb_addr", bus.wb_addr, 0);
        check("mid_rst_wb_data", bus.wb_data, 0);
        check("mid_rst_wb_parity", bus.wb_parity, 0);
        check("mid_rst_rd_ready", bus.rd_ready, 0);
        check("mid_rst_ce_count", ce_count, 0);
        check("mid_rst_ue_count", ue_count, 0);
        check("mid_rst_last_err_valid", last_err_valid, 0);
        check("mid_rst_last_err_addr", last_err_addr, 0);
        check("mid_rst_last_err_ue", last_err_ue, 0);
        @(negedge clk) rst = 1'b0;
        bus.resp_ready = 1'b1; bus.wb_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("post_rst_rd_ready", bus.rd_ready, 1);
            check("post_rst_resp_valid", bus.resp_valid, 0);
            check("post_rst_wb_valid", bus.wb_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
